// File: rtl/alu_serial.sv
// alu_serial: sequential ALU with nibble-serial add/subtract/compare and single-cycle
// logic and shift operations. Results and NVZCH flags are registered and held until the
// next completion.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              request strobe, sampled only while idle
//   op                 0 ADC, 1 SBC, 2 AND, 3 OR, 4 XOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 CMP
//   a, mem             accumulator and memory operands
//   target_bus         shift source select (0 = a, 1 = mem)
//   carry_in           ADC/SBC carry, ROL/ROR fill bit
//   decimal            BCD mode for ADC/SBC
//   busy               arithmetic operation in progress
//   done               one-cycle completion pulse
//   result             registered result
//   overflow, carry, half_carry, zero, negative   registered flags
//
// WIDTH must be a multiple of 4 and at least 8; WIDTH/4 must be divisible by NIB_PER_CYC.
module alu_serial #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NIB_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] mem,
    input  logic             target_bus,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic             half_carry,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned GW = 4 * NIB_PER_CYC;        // bits per arithmetic cycle
    localparam int unsigned K  = WIDTH / GW;             // arithmetic cycle count
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [3:0] OpAdc = 4'd0;
    localparam logic [3:0] OpSbc = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpAsl = 4'd5;
    localparam logic [3:0] OpLsr = 4'd6;
    localparam logic [3:0] OpRol = 4'd7;
    localparam logic [3:0] OpRor = 4'd8;
    localparam logic [3:0] OpCmp = 4'd9;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;      // remaining a nibbles, consumed LSB first
    logic [WIDTH-1:0] opm_q, opm_d;      // remaining mem nibbles, pre-inverted for subtract
    logic [WIDTH-1:0] sum_q, sum_d;      // result nibbles shifted in from the top
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;        // running carry between groups
    logic             dec_q, dec_d;
    logic             sub_q, sub_d;
    logic             ven_q, ven_d;      // overflow reported (ADC/SBC only)
    logic             hc_q, hc_d;        // nibble-0 carry captured in group 0

    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             v_q, v_d;
    logic             c_q, c_d;
    logic             h_q, h_d;
    logic             z_q, z_d;
    logic             n_q, n_d;

    // One group of nibbles through the adder with optional BCD adjust.
    logic [GW-1:0]    grp_res;
    logic             grp_cout;
    logic             grp_h;
    logic             grp_bin_msb;
    logic             grp_a_msb;
    logic             grp_m_msb;
    logic             chain_c;
    logic [3:0]       nib_a;
    logic [3:0]       nib_m;
    logic [4:0]       s_bin;
    logic [4:0]       s_adj;

    always_comb begin
        chain_c     = cy_q;
        grp_res     = '0;
        grp_h       = 1'b0;
        grp_bin_msb = 1'b0;
        grp_a_msb   = 1'b0;
        grp_m_msb   = 1'b0;
        nib_a       = '0;
        nib_m       = '0;
        s_bin       = '0;
        s_adj       = '0;
        for (int j = 0; j < int'(NIB_PER_CYC); j++) begin
            nib_a = opa_q[4*j +: 4];
            nib_m = opm_q[4*j +: 4];
            s_bin = {1'b0, nib_a} + {1'b0, nib_m} + {4'b0, chain_c};
            s_adj = s_bin;
            if (dec_q && !sub_q) begin
                if (s_bin > 5'd9) begin
                    s_adj   = s_bin + 5'd6;
                    chain_c = 1'b1;
                end else begin
                    chain_c = 1'b0;
                end
            end else begin
                chain_c = s_bin[4];
                // BCD subtract: a nibble that borrowed wraps by 16, pull it back into 0..9
                if (dec_q && !s_bin[4]) begin
                    s_adj = s_bin - 5'd6;
                end
            end
            grp_res[4*j +: 4] = s_adj[3:0];
            if (j == 0) begin
                grp_h = chain_c;
            end
            if (j == int'(NIB_PER_CYC) - 1) begin
                grp_bin_msb = s_bin[3];
                grp_a_msb   = nib_a[3];
                grp_m_msb   = nib_m[3];
            end
        end
        grp_cout = chain_c;
    end

    // Single-cycle operations straight from the inputs.
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] imm_res;
    logic             imm_c;

    always_comb begin
        src     = target_bus ? mem : a;
        imm_res = '0;
        imm_c   = 1'b0;
        case (op)
            OpAnd: imm_res = a & mem;
            OpOr:  imm_res = a | mem;
            OpXor: imm_res = a ^ mem;
            OpAsl: begin
                imm_res = {src[WIDTH-2:0], 1'b0};
                imm_c   = src[WIDTH-1];
            end
            OpLsr: begin
                imm_res = {1'b0, src[WIDTH-1:1]};
                imm_c   = src[0];
            end
            OpRol: begin
                imm_res = {src[WIDTH-2:0], carry_in};
                imm_c   = src[WIDTH-1];
            end
            OpRor: begin
                imm_res = {carry_in, src[WIDTH-1:1]};
                imm_c   = src[0];
            end
            default: begin
                imm_res = '0;
                imm_c   = 1'b0;
            end
        endcase
    end

    logic [WIDTH-1:0] sum_next;
    assign sum_next = (sum_q >> GW) | (WIDTH'(grp_res) << (WIDTH - GW));

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opm_d   = opm_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        dec_d   = dec_q;
        sub_d   = sub_q;
        ven_d   = ven_q;
        hc_d    = hc_q;
        res_d   = res_q;
        done_d  = 1'b0;
        v_d     = v_q;
        c_d     = c_q;
        h_d     = h_q;
        z_d     = z_q;
        n_d     = n_q;
        busy    = (state_q == StRun);

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (op == OpAdc || op == OpSbc || op == OpCmp) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        sum_d   = '0;
                        opa_d   = a;
                        sub_d   = (op != OpAdc);
                        opm_d   = (op != OpAdc) ? ~mem : mem;
                        cy_d    = (op == OpCmp) ? 1'b1 : carry_in;
                        dec_d   = (op != OpCmp) && decimal;
                        ven_d   = (op != OpCmp);
                    end else begin
                        res_d  = imm_res;
                        c_d    = imm_c;
                        v_d    = 1'b0;
                        h_d    = 1'b0;
                        n_d    = imm_res[WIDTH-1];
                        z_d    = (imm_res == '0);
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                opa_d = opa_q >> GW;
                opm_d = opm_q >> GW;
                cy_d  = grp_cout;
                sum_d = sum_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == '0) begin
                    hc_d = grp_h;
                end
                if (cnt_q == CW'(K - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    res_d   = sum_next;
                    c_d     = grp_cout;
                    h_d     = (cnt_q == '0) ? grp_h : hc_q;
                    // Signed overflow from the unadjusted top-nibble sum
                    v_d     = ven_q && (grp_a_msb == grp_m_msb) && (grp_bin_msb != grp_a_msb);
                    n_d     = sum_next[WIDTH-1];
                    z_d     = (sum_next == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opm_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            dec_q   <= 1'b0;
            sub_q   <= 1'b0;
            ven_q   <= 1'b0;
            hc_q    <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            h_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opm_q   <= opm_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            dec_q   <= dec_d;
            sub_q   <= sub_d;
            ven_q   <= ven_d;
            hc_q    <= hc_d;
            res_q   <= res_d;
            done_q  <= done_d;
            v_q     <= v_d;
            c_q     <= c_d;
            h_q     <= h_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign done       = done_q;
    assign result     = res_q;
    assign overflow   = v_q;
    assign carry      = c_q;
    assign half_carry = h_q;
    assign zero       = z_q;
    assign negative   = n_q;

endmodule

// File: tb/tb_alu_serial.sv
`timescale 1ns/1ps
module tb_alu_serial;

    typedef struct packed {
        logic [15:0] res;
        logic        v;
        logic        c;
        logic        h;
        logic        z;
        logic        n;
    } exp_t;

    // Instance 0: WIDTH=8/NIB=1, 1: WIDTH=16/NIB=1, 2: WIDTH=16/NIB=2
    localparam int DW [3] = '{8, 16, 16};
    localparam int DK [3] = '{2, 4, 2};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] mem;
    logic        target_bus;
    logic        carry_in;
    logic        decimal;

    logic        busy_w [3];
    logic        done_w [3];
    logic        v_w    [3];
    logic        c_w    [3];
    logic        h_w    [3];
    logic        z_w    [3];
    logic        n_w    [3];
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [15:0] res16w;
    logic [15:0] res_w  [3];

    assign res_w[0] = {8'h00, res8};
    assign res_w[1] = res16;
    assign res_w[2] = res16w;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(8), .NIB_PER_CYC(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a[7:0]), .mem(mem[7:0]),
        .target_bus(target_bus), .carry_in(carry_in), .decimal(decimal),
        .busy(busy_w[0]), .done(done_w[0]), .result(res8), .overflow(v_w[0]),
        .carry(c_w[0]), .half_carry(h_w[0]), .zero(z_w[0]), .negative(n_w[0])
    );

    alu_serial #(.WIDTH(16), .NIB_PER_CYC(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .mem(mem),
        .target_bus(target_bus), .carry_in(carry_in), .decimal(decimal),
        .busy(busy_w[1]), .done(done_w[1]), .result(res16), .overflow(v_w[1]),
        .carry(c_w[1]), .half_carry(h_w[1]), .zero(z_w[1]), .negative(n_w[1])
    );

    alu_serial #(.WIDTH(16), .NIB_PER_CYC(2)) dut16w (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .mem(mem),
        .target_bus(target_bus), .carry_in(carry_in), .decimal(decimal),
        .busy(busy_w[2]), .done(done_w[2]), .result(res16w), .overflow(v_w[2]),
        .carry(c_w[2]), .half_carry(h_w[2]), .zero(z_w[2]), .negative(n_w[2])
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Architectural result of one operation at width w, from the operation rules alone.
    function automatic exp_t model(input int w, input int opc, input int av_in, input int mv_in,
                                   input bit tb, input bit ci, input bit dec);
        exp_t r;
        int mask, av, mv, res, s, c, mm, an, mn, bin_msb, src;
        bit sub, d;
        mask = (1 << w) - 1;
        av   = av_in & mask;
        mv   = mv_in & mask;
        r    = '0;
        res  = 0;
        case (opc)
            0, 1, 9: begin
                sub = (opc != 0);
                d   = dec && (opc != 9);
                c   = (opc == 9) ? 1 : int'(ci);
                mm  = sub ? (~mv & mask) : mv;
                if (!d) begin
                    s   = av + mm + c;
                    res = s & mask;
                    c   = (s >> w) & 1;
                    r.h = (((av & 15) + (mm & 15) + ((opc == 9) ? 1 : int'(ci))) > 15);
                    if (opc != 9) r.v = 1'((((av ^ res) & (mm ^ res)) >> (w - 1)) & 1);
                end else begin
                    for (int i = 0; i < w / 4; i++) begin
                        an      = (av >> (4 * i)) & 15;
                        mn      = (mm >> (4 * i)) & 15;
                        s       = an + mn + c;
                        bin_msb = (s >> 3) & 1;
                        if (!sub) begin
                            if (s > 9) begin
                                s = s + 6;
                                c = 1;
                            end else begin
                                c = 0;
                            end
                        end else begin
                            c = (s >> 4) & 1;
                            if (c == 0) s = s - 6;
                        end
                        res = res | ((s & 15) << (4 * i));
                        if (i == 0) r.h = 1'(c);
                        if (i == w / 4 - 1)
                            r.v = (((an >> 3) & 1) == ((mn >> 3) & 1)) && (bin_msb != ((an >> 3) & 1));
                    end
                end
                r.c = 1'(c);
            end
            2: res = av & mv;
            3: res = av | mv;
            4: res = av ^ mv;
            5, 6, 7, 8: begin
                src = tb ? mv : av;
                case (opc)
                    5: begin res = (src << 1) & mask;              r.c = 1'((src >> (w - 1)) & 1); end
                    6: begin res = src >> 1;                       r.c = 1'(src & 1); end
                    7: begin res = ((src << 1) | int'(ci)) & mask; r.c = 1'((src >> (w - 1)) & 1); end
                    default: begin
                        res = (src >> 1) | (int'(ci) << (w - 1));
                        r.c = 1'(src & 1);
                    end
                endcase
            end
            default: res = 0;
        endcase
        r.res = 16'(res);
        r.z   = (res == 0);
        r.n   = 1'((res >> (w - 1)) & 1);
        return r;
    endfunction

    // Transaction-level expectation per instance: latency K+1 for arithmetic, 1 otherwise.
    exp_t m_out  [3];
    exp_t m_pend [3];
    int   m_rem  [3];
    bit   m_done [3];
    bit   model_ready = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_rem[d]  <= 0;
                m_done[d] <= 1'b0;
                m_out[d]  <= '0;
            end else if (m_rem[d] > 0) begin
                m_rem[d] <= m_rem[d] - 1;
                if (m_rem[d] == 1) begin
                    m_out[d]  <= m_pend[d];
                    m_done[d] <= 1'b1;
                end else begin
                    m_done[d] <= 1'b0;
                end
            end else if (start) begin
                if (op == 4'd0 || op == 4'd1 || op == 4'd9) begin
                    m_pend[d] <= model(DW[d], int'(op), int'(a), int'(mem), target_bus, carry_in,
                                       decimal);
                    m_rem[d]  <= DK[d];
                    m_done[d] <= 1'b0;
                end else begin
                    m_out[d]  <= model(DW[d], int'(op), int'(a), int'(mem), target_bus, carry_in,
                                       decimal);
                    m_done[d] <= 1'b1;
                end
            end else begin
                m_done[d] <= 1'b0;
            end
        end
        model_ready <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_ready) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d busy", d),   busy_w[d], m_rem[d] > 0);
                chk($sformatf("dut%0d done", d),   done_w[d], m_done[d]);
                chk($sformatf("dut%0d result", d), res_w[d],  m_out[d].res);
                chk($sformatf("dut%0d V", d),      v_w[d],    m_out[d].v);
                chk($sformatf("dut%0d C", d),      c_w[d],    m_out[d].c);
                chk($sformatf("dut%0d H", d),      h_w[d],    m_out[d].h);
                chk($sformatf("dut%0d Z", d),      z_w[d],    m_out[d].z);
                chk($sformatf("dut%0d N", d),      n_w[d],    m_out[d].n);
            end
        end
    end

    // Called just after a rising edge.
    task automatic wait_idle();
        for (int i = 0; i < 20 && (busy_w[0] || busy_w[1] || busy_w[2]); i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [3:0] o, input logic [15:0] av, input logic [15:0] mv,
                       input logic tb, input logic ci, input logic dc, input int sel,
                       output int lat);
        wait_idle();
        op         = o;
        a          = av;
        mem        = mv;
        target_bus = tb;
        carry_in   = ci;
        decimal    = dc;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;   // later input changes must not affect the operation
        mem   = ~mv;
        lat   = 1;
        while (!done_w[sel] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int lat;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        op         = 4'd0;
        a          = '0;
        mem        = '0;
        target_bus = 1'b0;
        carry_in   = 1'b0;
        decimal    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", res8, 8'h00);
        chk("reset busy", busy_w[0], 1'b0);
        chk("reset done", done_w[0], 1'b0);
        chk("reset zero", z_w[0], 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(4'd0, 16'h0050, 16'h0050, 1'b0, 1'b0, 1'b0, 0, lat);
        chk("adc_bin latency", lat, 3);
        chk("adc_bin result", res8, 8'hA0);
        chk("adc_bin V", v_w[0], 1'b1);
        chk("adc_bin N", n_w[0], 1'b1);
        chk("adc_bin C", c_w[0], 1'b0);
        chk("adc_bin Z", z_w[0], 1'b0);
        chk("adc_bin H", h_w[0], 1'b0);

        run(4'd0, 16'h0099, 16'h0001, 1'b0, 1'b0, 1'b1, 0, lat);
        chk("adc_dec result", res8, 8'h00);
        chk("adc_dec C", c_w[0], 1'b1);
        chk("adc_dec Z", z_w[0], 1'b1);
        chk("adc_dec H", h_w[0], 1'b1);
        chk("adc_dec N", n_w[0], 1'b0);

        run(4'd1, 16'h0042, 16'h0013, 1'b0, 1'b1, 1'b1, 0, lat);
        chk("sbc_dec result", res8, 8'h29);
        chk("sbc_dec C", c_w[0], 1'b1);

        run(4'd9, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1, 0, lat);
        chk("cmp result", res8, 8'hF0);
        chk("cmp C", c_w[0], 1'b0);
        chk("cmp N", n_w[0], 1'b1);

        run(4'd8, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 0, lat);
        chk("ror latency", lat, 1);
        chk("ror result", res8, 8'h80);
        chk("ror C", c_w[0], 1'b1);
        chk("ror N", n_w[0], 1'b1);
        chk("ror busy", busy_w[0], 1'b0);

        run(4'd5, 16'h0000, 16'h0080, 1'b1, 1'b0, 1'b0, 0, lat);
        chk("asl_mem result", res8, 8'h00);
        chk("asl_mem C", c_w[0], 1'b1);
        chk("asl_mem Z", z_w[0], 1'b1);

        // AND request while an ADC is running is dropped
        wait_idle();
        op = 4'd0; a = 16'h0050; mem = 16'h0050; carry_in = 1'b0; decimal = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        op = 4'd2; a = 16'h000F; mem = 16'h00FF;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 2;
        while (!done_w[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ignored_start latency", lat, 3);
        chk("ignored_start result", res8, 8'hA0);
        @(posedge clk);
        #1;
        chk("ignored_start no second done", done_w[0], 1'b0);

        // Reset in cycle 2 of an ADC aborts it
        wait_idle();
        op = 4'd0; a = 16'h0011; mem = 16'h0022;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort result", res8, 8'h00);
        chk("abort done", done_w[0], 1'b0);
        chk("abort busy", busy_w[0], 1'b0);
        chk("abort N", n_w[0], 1'b0);
        chk("abort busy16", busy_w[1], 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("abort late done", done_w[0], 1'b0);
        end

        run(4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1, lat);
        chk("adc16 latency", lat, 5);
        chk("adc16 result", res16, 16'h0000);
        chk("adc16 C", c_w[1], 1'b1);
        chk("adc16 Z", z_w[1], 1'b1);

        run(4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2, lat);
        chk("adc16w latency", lat, 3);
        chk("adc16w result", res16w, 16'h0000);
        chk("adc16w C", c_w[2], 1'b1);

        // Further vectors checked by the model on every instance
        run(4'd1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1, lat);
        run(4'd1, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b0, 0, lat);
        chk("sbc_bin result", res8, 8'h7F);
        chk("sbc_bin V", v_w[0], 1'b1);
        run(4'd0, 16'h1958, 16'h2746, 1'b0, 1'b1, 1'b1, 1, lat);
        chk("adc_dec16 result", res16, 16'h4705);
        run(4'd1, 16'h1000, 16'h0001, 1'b0, 1'b1, 1'b1, 1, lat);
        run(4'd4, 16'hA5C3, 16'hFF0F, 1'b0, 1'b0, 1'b0, 0, lat);
        run(4'd6, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 0, lat);
        run(4'd7, 16'h0000, 16'h4081, 1'b1, 1'b1, 1'b0, 0, lat);
        run(4'd3, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, lat);
        run(4'd13, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b1, 0, lat);
        chk("reserved Z", z_w[0], 1'b1);
        run(4'd9, 16'h3C3C, 16'h3C3C, 1'b0, 1'b0, 1'b0, 1, lat);
        chk("cmp_eq C", c_w[1], 1'b1);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
